fetch_queue: RTL and testbench

//   Parametrised IF stage for the pipelined MIPS core: owns the PC, fetches from
//   a variable-latency instruction memory via req/ack, and buffers fetched words
//   in a DEPTH-entry prefetch FIFO feeding decode. Supports a decode stall
//   (stallF) and a redirect from EX (branch/jump) that flushes queue and in-flight fetch.

---
 rtl/fetch_queue.sv | 197 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, fetches over imem req/ack, buffers words in a prefetch FIFO.
// Latency: ack at edge N makes the word visible on validF/instrF from edge N when the FIFO was empty.
// Backpressure: stallF holds the head entry; new requests are issued only while count < DEPTH.
// Optional build macro FETCH_PERF_EN adds saturating stall/empty/redirect performance counters.
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallF,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             validF,
    output logic [31:0]      instrF,
    output logic [WIDTH-1:0] pcplus4F
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_empty_cnt,
    output logic [31:0]      perf_redirect_cnt
`endif
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] FOUR    = WIDTH'(4);

    // IDLE: no request outstanding. WAIT: live request. DISCARD: request
    // still outstanding on the bus but its data belongs to a flushed stream.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    logic [31:0]        instr_mem [DEPTH];
    logic [WIDTH-1:0]   pc4_mem   [DEPTH];

    logic               issue;
    logic               push;
    logic               pop;
    logic [WIDTH-1:0]   redirect_aligned;
    logic [WIDTH-1:0]   addr_plus4;

    // Instruction words are always fetched on a word boundary.
    assign redirect_aligned = redirect_pc & ~WIDTH'(3);
    assign addr_plus4       = addr_q + FOUR;

    // Head of the FIFO drives decode; NOP and zero PC when empty.
    assign validF    = (count_q != '0);
    assign instrF    = validF ? instr_mem[rd_ptr_q] : 32'h0;
    assign pcplus4F  = validF ? pc4_mem[rd_ptr_q]   : '0;

    // Request is a pure function of registered state, so it never glitches.
    assign imem_req  = (state_q != S_IDLE);
    assign imem_addr = addr_q;

    // Redirect outranks consumption; stallF never blocks a flush.
    assign pop = validF && !stallF && !redirect;

    // Next-state logic for the fetch FSM; decides when to issue and push.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Issue only with a free slot so the ack always has room.
                if (!redirect && (count_q < DEPTH_C)) begin
                    state_d = S_WAIT;
                    issue   = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                    push    = !redirect;
                end else if (redirect) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // The stale word arrives and is dropped; a further redirect
                // only changes the PC, the bus handshake still has to finish.
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // PC, request address, FIFO pointers and occupancy for the next edge.
    always_comb begin
        pc_d     = pc_q;
        addr_d   = addr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (issue) begin
            addr_d = pc_q;
        end

        if (redirect) begin
            pc_d     = redirect_aligned;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = addr_plus4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc4_mem[wr_ptr_q]   <= addr_plus4;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt_q;
    logic [31:0] perf_empty_cnt_q;
    logic [31:0] perf_redirect_cnt_q;

    assign perf_stall_cnt    = perf_stall_cnt_q;
    assign perf_empty_cnt    = perf_empty_cnt_q;
    assign perf_redirect_cnt = perf_redirect_cnt_q;

    // Saturating event counters: decode stalls, empty cycles, redirects.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cnt_q    <= '0;
            perf_empty_cnt_q    <= '0;
            perf_redirect_cnt_q <= '0;
        end else begin
            if (validF && stallF && (perf_stall_cnt_q != '1)) begin
                perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
            end
            if (!validF && (perf_empty_cnt_q != '1)) begin
                perf_empty_cnt_q <= perf_empty_cnt_q + 32'd1;
            end
            if (redirect && (perf_redirect_cnt_q != '1)) begin
                perf_redirect_cnt_q <= perf_redirect_cnt_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table plus multi-cycle sequences.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// The memory model in the sequences acks every cycle a request is visible.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        stallF;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        validF;
    logic [31:0] instrF;
    logic [31:0] pcplus4F;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_empty_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .stallF      (stallF),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .validF      (validF),
        .instrF      (instrF),
        .pcplus4F    (pcplus4F)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_empty_cnt    (perf_empty_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stall, input logic redir,
                       input logic [31:0] rpc, input logic ack, input logic [31:0] rdata,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4);
        vec_t v;
        v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc;
        v.ack = ack; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc4 = e_pc4;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4);
        chk({tag, " req"},   {31'b0, imem_req}, {31'b0, e_req});
        if (e_req) chk({tag, " addr"}, imem_addr, e_addr);
        chk({tag, " valid"}, {31'b0, validF},   {31'b0, e_valid});
        chk({tag, " instr"}, instrF,   e_instr);
        chk({tag, " pc4"},   pcplus4F, e_pc4);
    endtask

    logic [31:0] pop_instr [5];
    logic [31:0] pop_pc4   [5];
    int          npop;
    int          pushes;
    logic [31:0] first_req_addr;
    logic        seen_req;

    initial begin
        reset = 1'b0; stallF = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0;

        //   rst stall redir rpc           ack rdata          req addr          valid instr         pc4
        add(0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0);
        add(0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0);
        add(1, 0, 0, 32'h0,          0, 32'h0,        1, 32'h0,         0, 32'h0,        32'h0);
        add(1, 0, 0, 32'h0,          1, 32'hA0000000, 0, 32'h0,         1, 32'hA0000000, 32'h4);
        add(1, 0, 0, 32'h0,          0, 32'h0,        1, 32'h4,         0, 32'h0,        32'h0);
        add(1, 0, 0, 32'h0,          1, 32'hA0000004, 0, 32'h0,         1, 32'hA0000004, 32'h8);
        add(1, 0, 0, 32'h0,          0, 32'h0,        1, 32'h8,         0, 32'h0,        32'h0);
        add(1, 0, 0, 32'h0,          1, 32'hA0000008, 0, 32'h0,         1, 32'hA0000008, 32'hC);
        add(1, 0, 1, 32'hFFFFFFFE,   0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0);
        add(1, 0, 0, 32'h0,          0, 32'h0,        1, 32'hFFFFFFFC,  0, 32'h0,        32'h0);
        add(1, 0, 0, 32'h0,          1, 32'h11111111, 0, 32'h0,         1, 32'h11111111, 32'h0);
        add(1, 1, 0, 32'h0,          0, 32'h0,        1, 32'h0,         1, 32'h11111111, 32'h0);
        add(1, 1, 1, 32'h200,        1, 32'hDEADBEEF, 0, 32'h0,         0, 32'h0,        32'h0);
        add(1, 1, 0, 32'h0,          0, 32'h0,        1, 32'h200,       0, 32'h0,        32'h0);
        add(1, 1, 0, 32'h0,          1, 32'h22222222, 0, 32'h0,         1, 32'h22222222, 32'h204);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; stallF = vecs[i].stall; redirect = vecs[i].redir;
            redirect_pc = vecs[i].rpc; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
            step();
            chk_out($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                    vecs[i].e_instr, vecs[i].e_pc4);
        end

        // Fill under stall: flush first, then exactly four words fit.
        stallF = 1'b1; redirect = 1'b1; redirect_pc = 32'h300; imem_ack = 1'b0;
        step();
        redirect = 1'b0;
        chk("fill flush valid", {31'b0, validF}, 32'h0);
        pushes = 0;
        for (int c = 0; c < 10; c++) begin
            imem_ack = imem_req;
            imem_rdata = {16'hC0DE, imem_addr[15:0]};
            if (imem_req) pushes++;
            step();
        end
        chk("fill pushes", pushes, 32'd4);
        chk_out("fill full", 1'b0, 32'h0, 1'b1, 32'hC0DE0300, 32'h304);

        // Release: drain in order, then fetch resumes after the last fill word.
        stallF = 1'b0; npop = 0; seen_req = 1'b0; first_req_addr = '0;
        for (int c = 0; c < 30 && npop < 5; c++) begin
            imem_ack = imem_req;
            imem_rdata = {16'hC0DE, imem_addr[15:0]};
            if (validF) begin
                pop_instr[npop] = instrF;
                pop_pc4[npop]   = pcplus4F;
                npop++;
            end
            if (imem_req && !seen_req) begin
                seen_req = 1'b1;
                first_req_addr = imem_addr;
            end
            step();
        end
        chk("drain pop count", npop, 32'd5);
        chk("drain resume addr", first_req_addr, 32'h310);
        for (int k = 0; k < npop; k++) begin
            chk($sformatf("drain%0d instr", k), pop_instr[k], 32'hC0DE0300 + 32'(4 * k));
            chk($sformatf("drain%0d pc4", k),   pop_pc4[k],   32'h304 + 32'(4 * k));
        end

        // Reset with a request in flight, then late ack after a redirect.
        imem_ack = 1'b0; stallF = 1'b1;
        step();
        chk("midfetch req", {31'b0, imem_req}, 32'h1);
        reset = 1'b0;
        step();
        chk_out("rst mid", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1; stallF = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0BAD0;
        step();
        chk_out("rst ack ignored", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        imem_ack = 1'b0;
        step();
        chk_out("wait hold", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk_out("discard", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        chk_out("discard hold", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hBAD00000;
        step();
        chk_out("late ack dropped", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        imem_ack = 1'b0;
        step();
        chk_out("redir req", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h33333333;
        step();
        imem_ack = 1'b0;
        chk_out("redir data", 1'b0, 32'h0, 1'b1, 32'h33333333, 32'h104);

`ifdef FETCH_PERF_EN
        reset = 1'b0; redirect = 1'b0;
        step();
        chk("perf rst stall", perf_stall_cnt, 32'd0);
        chk("perf rst redir", perf_redirect_cnt, 32'd0);
        reset = 1'b1; stallF = 1'b1;
        for (int c = 0; c < 7; c++) begin
            imem_ack = imem_req;
            imem_rdata = 32'h44444444;
            step();
        end
        imem_ack = 1'b0; stallF = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        step();
        redirect = 1'b0;
        step();
        chk("perf stall", perf_stall_cnt, 32'd5);
        chk("perf redir", perf_redirect_cnt, 32'd2);
        reset = 1'b0;
        step();
        chk("perf clr stall", perf_stall_cnt, 32'd0);
        chk("perf clr empty", perf_empty_cnt, 32'd0);
        chk("perf clr redir", perf_redirect_cnt, 32'd0);
        reset = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
